data_mem_responder: RTL and testbench

Responder end of the data-memory interface driven by the control unit. It consumes the active-low `memRead` / `memWrite` strobes together with the ALU-computed address and store data, performs a word access into on-chip data RAM with a configurable number of wait states, and returns load data with a one-cycle `ready` pulse. It asserts `stall` back to the pipeline while an access is in flight.

---
 rtl/data_mem_responder_pkg.sv | 16 +
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/dm_ram.sv | 29 ++
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 tb/tb_data_mem_responder.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// FSM encodings, strobe polarity and data width.
package data_mem_responder_pkg;

    localparam int unsigned DATA_W = 32;

    // Control-unit strobes are active-low.
    localparam logic MEM_ASSERT = 1'b0;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the control unit (master) and the responder (slave).
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic              memRead;
    logic              memWrite;
    logic [31:0]       address;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;
    logic              ready;
    logic              stall;
    logic              error;

    modport master (
        output memRead, memWrite, address, writeData,
        input  readData, ready, stall, error
    );

    modport slave (
        input  memRead, memWrite, address, writeData,
        output readData, ready, stall, error
    );

endinterface

// File: rtl/dm_ram.sv
// Single-port word RAM with synchronous write and registered read.
// The array has no reset so its contents survive a responder reset.
module dm_ram #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the control unit's data-memory port: latches a request, waits
// WAIT_STATES cycles, then pulses ready; faulted accesses still run full latency.
module data_mem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    data_mem_responder_if.slave bus
);
    import data_mem_responder_pkg::*;

    localparam logic [3:0]  WaitInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    // Address bits above the RAM word index must all be zero.
    localparam logic [31:0] HiMask   = ~((32'd1 << (ADDR_W + 2)) - 32'd1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              is_write_q, is_write_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              error_q, error_d;
    logic              rzero_q, rzero_d;

    logic              rd_req, wr_req, req_valid, req_both, addr_fault;
    logic [ADDR_W-1:0] in_idx, ram_addr;
    logic              ram_we, ram_re, stall, ready;
    logic [DATA_W-1:0] ram_rdata;

    assign rd_req     = (bus.memRead == MEM_ASSERT);
    assign wr_req     = (bus.memWrite == MEM_ASSERT);
    assign req_valid  = rd_req ^ wr_req;
    assign req_both   = rd_req & wr_req;
    assign in_idx     = bus.address[ADDR_W+1:2];
    assign addr_fault = (|bus.address[1:0]) | (|(bus.address & HiMask));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        fault_d    = fault_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        error_d    = error_q;
        rzero_d    = rzero_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        stall      = 1'b0;
        ready      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_both) begin
                    error_d = 1'b1;
                end else if (req_valid) begin
                    stall      = 1'b1;
                    is_write_d = wr_req;
                    fault_d    = addr_fault;
                    idx_d      = in_idx;
                    wdata_d    = bus.writeData;
                    cnt_d      = WaitInit;
                    if (addr_fault) begin
                        error_d = 1'b1;
                    end
                    if (WAIT_STATES == 0) begin
                        // No wait states: the read must be issued on the accepting edge.
                        state_d = StDone;
                        if (rd_req) begin
                            ram_re  = ~addr_fault;
                            rzero_d = addr_fault;
                        end
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                stall = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                    if (!is_write_q) begin
                        ram_re  = ~fault_q;
                        rzero_d = fault_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                ready   = 1'b1;
                ram_we  = is_write_q & ~fault_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            is_write_q <= 1'b0;
            fault_q    <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            error_q    <= 1'b0;
            rzero_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            fault_q    <= fault_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            error_q    <= error_d;
            rzero_q    <= rzero_d;
        end
    end

    // Only the zero-latency read addresses the RAM straight from the bus.
    assign ram_addr = (state_q == StIdle) ? in_idx : idx_q;

    dm_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign bus.readData = rzero_q ? '0 : ram_rdata;
    assign bus.ready    = ready;
    assign bus.stall    = stall;
    assign bus.error    = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table-driven accesses on a 2-wait-state instance,
// hand-written sequences for zero wait states, reset, both-strobes and back-to-back.
module tb_data_mem_responder;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    data_mem_responder_if bus_a ();
    data_mem_responder_if bus_b ();

    data_mem_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    data_mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_err;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model [bit [9:0]];
    logic [31:0] exp_q [$];
    logic        err_model = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access on the WAIT_STATES=2 instance, expected data from the model.
    task automatic access_a(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        logic fault;
        logic seen;
        int   k;
        int   stall_cnt;
        fault = (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0);
        if (wr) begin
            if (!fault) model[addr[11:2]] = data;
        end else begin
            exp_q.push_back(fault ? 32'd0 : model[addr[11:2]]);
        end
        @(negedge clock);
        bus_a.memRead   = wr;
        bus_a.memWrite  = ~wr;
        bus_a.address   = addr;
        bus_a.writeData = data;
        seen      = 1'b0;
        stall_cnt = 0;
        for (k = 0; k < 20; k++) begin
            #1;
            if (k == 0) check("err_before", {31'd0, bus_a.error}, {31'd0, err_model});
            if (k == 1) begin
                err_model = err_model | fault;
                check("err_after", {31'd0, bus_a.error}, {31'd0, err_model});
            end
            if (bus_a.ready) begin
                seen = 1'b1;
                break;
            end
            stall_cnt += int'(bus_a.stall);
            @(negedge clock);
        end
        bus_a.memRead  = 1'b1;
        bus_a.memWrite = 1'b1;
        check("ready_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("latency", 32'(k), 32'd3);
            check("stall_cycles", 32'(stall_cnt), 32'd3);
            check("stall_in_done", {31'd0, bus_a.stall}, 32'd0);
            if (!wr) check("read_data", bus_a.readData, exp_q.pop_front());
        end
    endtask

    initial begin
        vec_t vecs [10];
        int   t0, t1, nr;
        logic got_ready;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0};
        vecs[2] = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0FFC, 32'h1357_9BDF, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b0};
        vecs[5] = '{1'b0, 32'h0000_0020, 32'h0,         1'b0};
        vecs[6] = '{1'b0, 32'h0000_0013, 32'h0,         1'b1};
        vecs[7] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1};
        vecs[8] = '{1'b1, 32'h0000_1010, 32'h5555_5555, 1'b1};
        vecs[9] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1};

        bus_a.memRead = 1'b1; bus_a.memWrite = 1'b1;
        bus_a.address = '0;   bus_a.writeData = '0;
        bus_b.memRead = 1'b1; bus_b.memWrite = 1'b1;
        bus_b.address = '0;   bus_b.writeData = '0;

        repeat (2) @(negedge clock);
        check("rst_rdata", bus_a.readData, 32'd0);
        check("rst_ready", {31'd0, bus_a.ready}, 32'd0);
        check("rst_stall", {31'd0, bus_a.stall}, 32'd0);
        check("rst_error", {31'd0, bus_a.error}, 32'd0);
        reset_n = 1'b1;

        // Zero wait states: store 0x12345678 to 0x0 then load it back.
        @(negedge clock);
        bus_b.memWrite = 1'b0; bus_b.address = 32'h0; bus_b.writeData = 32'h1234_5678;
        #1 check("ws0_st_stall", {31'd0, bus_b.stall}, 32'd1);
        check("ws0_st_idle_ready", {31'd0, bus_b.ready}, 32'd0);
        @(negedge clock); #1;
        check("ws0_st_ready", {31'd0, bus_b.ready}, 32'd1);
        check("ws0_st_done_stall", {31'd0, bus_b.stall}, 32'd0);
        bus_b.memWrite = 1'b1;
        @(negedge clock);
        bus_b.memRead = 1'b0; bus_b.address = 32'h0;
        exp_q.push_back(32'h1234_5678);
        #1 check("ws0_ld_stall", {31'd0, bus_b.stall}, 32'd1);
        @(negedge clock); #1;
        check("ws0_ld_ready", {31'd0, bus_b.ready}, 32'd1);
        check("ws0_ld_data", bus_b.readData, exp_q.pop_front());
        bus_b.memRead = 1'b1;
        @(negedge clock); #1;
        check("ws0_ready_pulse", {31'd0, bus_b.ready}, 32'd0);

        foreach (vecs[i]) begin
            access_a(vecs[i].wr, vecs[i].addr, vecs[i].data);
            check("vec_err", {31'd0, bus_a.error}, {31'd0, vecs[i].exp_err});
        end

        // Reset during BUSY of a store: the store must be dropped.
        @(negedge clock);
        bus_a.memWrite = 1'b0; bus_a.address = 32'h20; bus_a.writeData = 32'hAAAA_5555;
        @(negedge clock); #1;
        check("rst_mid_busy_stall", {31'd0, bus_a.stall}, 32'd1);
        bus_a.memWrite = 1'b1;
        reset_n = 1'b0;
        err_model = 1'b0;
        #1;
        check("rst_mid_rdata", bus_a.readData, 32'd0);
        check("rst_mid_ready", {31'd0, bus_a.ready}, 32'd0);
        check("rst_mid_stall", {31'd0, bus_a.stall}, 32'd0);
        check("rst_mid_error", {31'd0, bus_a.error}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        access_a(1'b0, 32'h20, 32'h0);

        // Both strobes low: error, no stall, no ready, RAM untouched.
        @(negedge clock);
        bus_a.memRead = 1'b0; bus_a.memWrite = 1'b0;
        bus_a.address = 32'h20; bus_a.writeData = 32'h9999_9999;
        got_ready = 1'b0;
        #1 check("both_stall", {31'd0, bus_a.stall}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock); #1;
            got_ready = got_ready | bus_a.ready;
        end
        check("both_error", {31'd0, bus_a.error}, 32'd1);
        check("both_no_ready", {31'd0, got_ready}, 32'd0);
        bus_a.memRead = 1'b1; bus_a.memWrite = 1'b1;
        err_model = 1'b1;
        access_a(1'b0, 32'h20, 32'h0);

        // Back-to-back loads with memRead held low across DONE.
        @(negedge clock);
        bus_a.memRead = 1'b0; bus_a.address = 32'h10;
        exp_q.push_back(model[10'd4]);
        exp_q.push_back(model[10'd4]);
        nr = 0; t0 = -1; t1 = -1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus_a.ready) begin
                if (nr == 0) t0 = c; else t1 = c;
                nr++;
                check("b2b_data", bus_a.readData, exp_q.pop_front());
                if (nr == 2) break;
            end
            @(negedge clock);
        end
        bus_a.memRead = 1'b1;
        check("b2b_pulses", 32'(nr), 32'd2);
        check("b2b_first", 32'(t0), 32'd3);
        check("b2b_spacing", 32'(t1 - t0), 32'd4);
        @(negedge clock); #1;
        check("b2b_idle_stall", {31'd0, bus_a.stall}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
